// File: rtl/kernel_pkg.sv
// Shared types and window geometry for the Zhang-Suen kernel units.
// Window bit k holds neighbour P(k+1); nb_offset gives its address offset from the centre.
package kernel_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [8:0] window_t;

    localparam int N_DEFAULT = 8;

    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int P3 = 2;
    localparam int P4 = 3;
    localparam int P5 = 4;
    localparam int P6 = 5;
    localparam int P7 = 6;
    localparam int P8 = 7;
    localparam int P9 = 8;

    function automatic int nb_offset(input int k, input int n);
        int off;
        case (k)
            P1:      off = 0;
            P2:      off = -n;
            P3:      off = -n + 1;
            P4:      off = 1;
            P5:      off = n + 1;
            P6:      off = n;
            P7:      off = n - 1;
            P8:      off = -1;
            P9:      off = -n - 1;
            default: off = 0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/kernel_ram_if.sv
// Shared pixel write bus plus per-unit evaluate strobe and result.
import kernel_pkg::*;

interface kernel_ram_if #(
    parameter int ADDR_W = 7
);
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    pixel_t            data_in;
    pixel_t            result;

    modport master (output we, output re, output addr, output data_in, input result);
    modport slave  (input we, input re, input addr, input data_in, output result);
endinterface

// File: rtl/kernel_ram_thin.sv
// Combinational Zhang-Suen deletion test on a captured 3x3 window.
import kernel_pkg::*;

module zs_thin_cond #(
    parameter int SUBITER = 0
) (
    input  window_t i_win,
    output logic    o_del
);
    logic [3:0] w_b;
    logic [2:0] w_a;
    logic       w_prod_ok;

    // Neighbour popcount B and 0->1 transition count A around the ring P2..P9,P2.
    always_comb begin
        w_b = 4'd0;
        w_a = 3'd0;
        for (int i = P2; i <= P9; i++) begin
            w_b = w_b + {3'b000, i_win[i]};
        end
        for (int i = P2; i <= P9; i++) begin
            if (!i_win[i] && i_win[(i == P9) ? P2 : i + 1]) begin
                w_a = w_a + 3'd1;
            end else begin
                w_a = w_a;
            end
        end
    end

    generate
        if (SUBITER == 0) begin : g_sub0
            assign w_prod_ok = !(i_win[P2] & i_win[P4] & i_win[P6]) &&
                               !(i_win[P4] & i_win[P6] & i_win[P8]);
        end else begin : g_sub1
            assign w_prod_ok = !(i_win[P2] & i_win[P4] & i_win[P8]) &&
                               !(i_win[P2] & i_win[P6] & i_win[P8]);
        end
    endgenerate

    assign o_del = i_win[P1] && (w_b >= 4'd2) && (w_b <= 4'd6) && (w_a == 3'd1) && w_prod_ok;

endmodule

// File: rtl/kernel_ram.sv
// Per-pixel thinning unit: snoops the pixel bus, captures its 3x3 window and
// on re registers the kept centre byte or 0. PADDED units always output 0.
import kernel_pkg::*;

module kernel_ram #(
    parameter int N       = N_DEFAULT,
    parameter int ADDR_W  = 7,
    parameter int PADDED  = 0,
    parameter int SUBITER = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] index,
    kernel_ram_if.slave       bus
);
    pixel_t r_result;

    assign bus.result = r_result;

    generate
        if (PADDED == 0) begin : g_interior
            localparam logic signed [ADDR_W:0] LAST = (ADDR_W + 1)'(N * N - 1);

            window_t r_win;
            window_t r_mask;
            pixel_t  r_centre;
            window_t w_win_nx;
            window_t w_mask_nx;
            window_t w_hit;
            pixel_t  w_next;
            logic    w_new_frame;
            logic    w_del;

            // Out-of-image neighbour positions (negative or past the last pixel) never match.
            for (genvar k = 0; k < 9; k++) begin : g_win
                localparam logic signed [ADDR_W:0] OFF = (ADDR_W + 1)'(nb_offset(k, N));
                logic signed [ADDR_W:0] w_pos;
                assign w_pos    = $signed({1'b0, index}) + OFF;
                assign w_hit[k] = bus.we && (w_pos[ADDR_W] == 1'b0) && (w_pos <= LAST) &&
                                  (w_pos[ADDR_W-1:0] == bus.addr);
            end

            assign w_new_frame = bus.we && (bus.addr == {ADDR_W{1'b0}});

            // Next window/mask: optional frame clear, then this cycle's capture.
            always_comb begin
                if (w_new_frame) begin
                    w_win_nx  = 9'h000;
                    w_mask_nx = 9'h000;
                end else begin
                    w_win_nx  = r_win;
                    w_mask_nx = r_mask;
                end
                for (int k = 0; k < 9; k++) begin
                    if (w_hit[k]) begin
                        w_win_nx[k]  = (bus.data_in != 8'h00);
                        w_mask_nx[k] = 1'b1;
                    end else begin
                        w_win_nx[k]  = w_win_nx[k];
                        w_mask_nx[k] = w_mask_nx[k];
                    end
                end
            end

            zs_thin_cond #(.SUBITER(SUBITER)) u_cond (
                .i_win (r_win),
                .o_del (w_del)
            );

            // Decision from the pre-edge window; incomplete windows yield 0.
            always_comb begin
                if (r_mask != 9'h1FF) begin
                    w_next = 8'h00;
                end else if (!r_win[P1] || w_del) begin
                    w_next = 8'h00;
                end else begin
                    w_next = r_centre;
                end
            end

            // Capture state, centre byte and result register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_win    <= 9'h000;
                    r_mask   <= 9'h000;
                    r_centre <= 8'h00;
                    r_result <= 8'h00;
                end else begin
                    r_win  <= w_win_nx;
                    r_mask <= w_mask_nx;
                    if (bus.we && (bus.addr == index)) begin
                        r_centre <= bus.data_in;
                    end
                    if (bus.re) begin
                        r_result <= w_next;
                    end
                end
            end
        end else begin : g_padded
            logic w_unused_bus;
            assign w_unused_bus = ^{bus.we, bus.re, bus.addr, bus.data_in, index};

            // Border units hold a constant zero result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_result <= 8'h00;
                end else begin
                    r_result <= 8'h00;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_kernel_ram.sv
// Directed bench: two interior units at index 18 (both sub-iterations) and one padded unit at index 0.
`timescale 1ns/1ps
import kernel_pkg::*;

module tb_kernel_ram;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_we;
    logic       tb_re;
    logic [6:0] tb_addr;
    logic [7:0] tb_din;
    logic [7:0] img [64];
    int         n_checks = 0;
    int         n_fail   = 0;

    kernel_ram_if #(.ADDR_W(7)) if0 ();
    kernel_ram_if #(.ADDR_W(7)) if1 ();
    kernel_ram_if #(.ADDR_W(7)) ifp ();

    assign if0.we = tb_we;  assign if0.re = tb_re;  assign if0.addr = tb_addr;  assign if0.data_in = tb_din;
    assign if1.we = tb_we;  assign if1.re = tb_re;  assign if1.addr = tb_addr;  assign if1.data_in = tb_din;
    assign ifp.we = tb_we;  assign ifp.re = tb_re;  assign ifp.addr = tb_addr;  assign ifp.data_in = tb_din;

    kernel_ram #(.N(8), .ADDR_W(7), .PADDED(0), .SUBITER(0)) u_s0 (.clk(clk), .rst_n(rst_n), .index(7'd18), .bus(if0));
    kernel_ram #(.N(8), .ADDR_W(7), .PADDED(0), .SUBITER(1)) u_s1 (.clk(clk), .rst_n(rst_n), .index(7'd18), .bus(if1));
    kernel_ram #(.N(8), .ADDR_W(7), .PADDED(1), .SUBITER(0)) u_pd (.clk(clk), .rst_n(rst_n), .index(7'd0),  .bus(ifp));

    always #5 clk = ~clk;

    task automatic check_px(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_img(input logic [7:0] v);
        for (int i = 0; i < 64; i++) img[i] = v;
    endtask

    task automatic load(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            for (int rep = 0; rep < 2; rep++) begin
                @(negedge clk);
                tb_we   = 1'b1;
                tb_addr = 7'(a);
                tb_din  = img[a];
            end
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic eval_pulse;
        @(negedge clk);
        tb_re = 1'b1;
        @(negedge clk);
        tb_re = 1'b0;
    endtask

    task automatic load_solid;
        clear_img(8'h00);
        img[9]  = 8'h80; img[10] = 8'h80; img[11] = 8'h80;
        img[17] = 8'h80; img[18] = 8'h80; img[19] = 8'h80;
        img[25] = 8'h80; img[26] = 8'h80; img[27] = 8'h80;
    endtask

    initial begin
        rst_n = 1'b0; tb_we = 1'b0; tb_re = 1'b0; tb_addr = 7'd0; tb_din = 8'h00;
        repeat (2) @(negedge clk);
        check_px("reset_s0", if0.result, 8'h00);
        check_px("reset_s1", if1.result, 8'h00);
        check_px("reset_pad", ifp.result, 8'h00);
        rst_n = 1'b1;

        clear_img(8'h00); img[18] = 8'hFF;
        load(0, 63); eval_pulse();
        check_px("isolated_s0", if0.result, 8'hFF);
        check_px("isolated_s1", if1.result, 8'hFF);
        check_px("isolated_pad", ifp.result, 8'h00);
        repeat (3) @(negedge clk);
        check_px("hold_s0", if0.result, 8'hFF);

        load_solid(); load(0, 63); eval_pulse();
        check_px("solid_s0", if0.result, 8'h80);
        check_px("solid_s1", if1.result, 8'h80);

        clear_img(8'h00);
        img[17] = 8'h01; img[18] = 8'h01; img[25] = 8'h01; img[26] = 8'h01;
        load(0, 63); eval_pulse();
        check_px("corner_s0", if0.result, 8'h00);
        check_px("corner_s1", if1.result, 8'h00);

        // P2..P6 set: sub-iteration 0 keeps (P2*P4*P6=1), sub-iteration 1 deletes
        clear_img(8'h00);
        img[10] = 8'h01; img[11] = 8'h01; img[19] = 8'h01; img[27] = 8'h01; img[26] = 8'h01;
        img[18] = 8'h5A;
        load(0, 63); eval_pulse();
        check_px("prod_s0", if0.result, 8'h5A);
        check_px("prod_s1", if1.result, 8'h00);

        // P2 and P6 only: A=2 keeps the pixel
        clear_img(8'h00);
        img[10] = 8'h01; img[26] = 8'h01; img[18] = 8'h33;
        load(0, 63); eval_pulse();
        check_px("a2_s0", if0.result, 8'h33);
        check_px("a2_s1", if1.result, 8'h33);

        // write to addr 0 with re in the same cycle: evaluate sees the old window
        @(negedge clk);
        tb_we = 1'b1; tb_addr = 7'd0; tb_din = 8'h00; tb_re = 1'b1;
        @(negedge clk);
        tb_we = 1'b0; tb_re = 1'b0;
        check_px("same_cycle_s0", if0.result, 8'h33);
        eval_pulse();
        check_px("after_clear_s0", if0.result, 8'h00);

        load_solid(); load(0, 63); eval_pulse();
        check_px("full_before_partial", if0.result, 8'h80);
        load(0, 20); eval_pulse();
        check_px("partial_s0", if0.result, 8'h00);
        check_px("partial_s1", if1.result, 8'h00);
        load(21, 63); eval_pulse();
        check_px("completed_s0", if0.result, 8'h80);
        check_px("completed_s1", if1.result, 8'h80);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check_px("midreset_async", if0.result, 8'h00);
        rst_n = 1'b1;
        eval_pulse();
        check_px("midreset_re_s0", if0.result, 8'h00);
        check_px("midreset_re_s1", if1.result, 8'h00);
        load(0, 63); eval_pulse();
        check_px("reload_s0", if0.result, 8'h80);

        clear_img(8'hFF);
        load(0, 63); eval_pulse();
        check_px("allff_s0", if0.result, 8'hFF);
        check_px("allff_pad", ifp.result, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
